// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; grant->req_ready is 2 cycles, one write per 3 cycles.
// Backpressure: no grant while full; an overflowed write waits in HOLD and retries until MAX_RETRY, then drops.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_drop,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          wr_ack,
  input  logic                          overflow,
  input  logic                          full,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  output logic [7:0]                    drop_cnt
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]      req_drop_q, req_drop_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
  logic [IDW-1:0]          gnt_id_q, gnt_id_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic                    busy_q, busy_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic [3:0]              retry_q, retry_d;

  logic [NUM_REQ-1:0]      elig;
  logic                    found;
  logic [IDW-1:0]          winner;
  logic [IDW-1:0]          gnt_next;
  logic [3:0]              retry_inc;

  // Any attempt without wr_ack counts as a failure, so overflow adds no information.
  logic unused_overflow;
  assign unused_overflow = overflow;

  // Masking the pulsed requester stops it being re-granted on its own ack/drop cycle.
  assign elig      = req_valid & ~req_ready_q & ~req_drop_q;
  assign gnt_next  = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
  assign retry_inc = retry_q + 4'd1;

  // Scanning downward lets the offset nearest the pointer win last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[(int'(rr_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    data_in_d   = data_in_q;
    gnt_id_d    = gnt_id_q;
    rr_d        = rr_q;
    retry_d     = retry_q;
    drop_cnt_d  = drop_cnt_q;
    req_ready_d = '0;
    req_drop_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !full) begin
          wr_en_d   = 1'b1;
          data_in_d = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
          gnt_id_d  = winner;
          retry_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (wr_ack) begin
          req_ready_d[gnt_id_q] = 1'b1;
          rr_d                  = gnt_next;
          state_d               = IDLE;
        end else begin
          retry_d = retry_inc;
          if (retry_inc == 4'(MAX_RETRY)) begin
            req_drop_d[gnt_id_q] = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            rr_d    = gnt_next;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!full) begin
          wr_en_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      data_in_q   <= '0;
      gnt_id_q    <= '0;
      rr_q        <= '0;
      retry_q     <= '0;
      drop_cnt_q  <= '0;
      req_ready_q <= '0;
      req_drop_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      data_in_q   <= data_in_d;
      gnt_id_q    <= gnt_id_d;
      rr_q        <= rr_d;
      retry_q     <= retry_d;
      drop_cnt_q  <= drop_cnt_d;
      req_ready_q <= req_ready_d;
      req_drop_q  <= req_drop_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_drop  = req_drop_q;
  assign wr_en     = wr_en_q;
  assign data_in   = data_in_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench: a small behavioural FIFO answers writes, and a transaction model
// (owner, attempt age, tries) predicts every arbiter output each cycle.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int MR    = 3;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, req_drop;
  logic            wr_en;
  logic [DW-1:0]   data_in;
  logic            wr_ack = 1'b0, overflow = 1'b0, full = 1'b0;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic [7:0]      drop_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_drop(req_drop), .wr_en(wr_en), .data_in(data_in),
    .wr_ack(wr_ack), .overflow(overflow), .full(full), .gnt_id(gnt_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Transaction model: owner=-1 means no grant outstanding; age counts edges since the last write pulse.
  int             m_ptr, m_owner, m_age, m_tries;
  logic [DW-1:0]  m_data;
  logic [IDW-1:0] m_gnt;
  logic [7:0]     m_dcnt;
  logic [N-1:0]   e_ready, e_drop;
  logic           e_wr;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_age = 0; m_tries = 0;
    m_data = '0; m_gnt = '0; m_dcnt = '0;
    e_ready = '0; e_drop = '0; e_wr = 1'b0;
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    if (!rst_n) begin
      model_reset();
      return;
    end
    elig    = req_valid & ~e_ready & ~e_drop;
    e_ready = '0;
    e_drop  = '0;
    e_wr    = 1'b0;
    if (m_owner < 0) begin
      if (elig != '0 && !full) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && elig[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        m_data  = req_data[m_owner*DW +: DW];
        m_gnt   = IDW'(m_owner);
        m_tries = 0;
        m_age   = 0;
        e_wr    = 1'b1;
      end
    end else begin
      m_age++;
      if (m_age == 2) begin
        if (wr_ack) begin
          e_ready[m_owner] = 1'b1;
          model_release();
        end else begin
          m_tries++;
          if (m_tries == MR) begin
            e_drop[m_owner] = 1'b1;
            if (m_dcnt != 8'hFF) m_dcnt++;
            model_release();
          end
        end
      end else if (m_age > 2 && !full) begin
        e_wr  = 1'b1;
        m_age = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("wr_en",     32'(wr_en),     32'(e_wr));
    check_eq("data_in",   32'(data_in),   32'(m_data));
    check_eq("gnt_id",    32'(gnt_id),    32'(m_gnt));
    check_eq("busy",      32'(busy),      32'(m_owner >= 0));
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("req_drop",  32'(req_drop),  32'(e_drop));
    check_eq("drop_cnt",  32'(drop_cnt),  32'(m_dcnt));
  endtask

  // Phases: random mix, saturated fairness, heavy backpressure, forced overflow (drop_cnt saturation), mix.
  int ph_cyc[5] = '{1500, 600, 1500, 3000, 1000};
  int ph_req[5] = '{40, 100, 60, 100, 30};
  int ph_pop[5] = '{50, 100, 10, 50, 30};
  int ph_inj[5] = '{20, 0, 0, 100, 30};
  int ph_rst[5] = '{1, 0, 1, 0, 1};

  logic [DW-1:0] fq[$];

  initial begin
    model_reset();
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < ph_cyc[p]; c++) begin
        logic          wr_before;
        logic [DW-1:0] din_before;
        logic          accept;
        model_step();
        wr_before  = wr_en;
        din_before = data_in;
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs();

        // FIFO: registered response to the write sampled at this edge.
        wr_ack   = 1'b0;
        overflow = 1'b0;
        if (wr_before) begin
          accept = (fq.size() < DEPTH) && ($urandom_range(99) >= ph_inj[p]);
          if (accept) begin
            fq.push_back(din_before);
            wr_ack   = 1'b1;
            overflow = ($urandom_range(9) == 0);
          end else begin
            overflow = ($urandom_range(3) != 0);
          end
        end
        if (fq.size() > 0 && $urandom_range(99) < ph_pop[p]) void'(fq.pop_front());
        full = (fq.size() == DEPTH);

        // Requesters hold valid/data until their pulse; sometimes re-request at once.
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] || req_drop[i]) begin
            if ($urandom_range(1) == 0) begin
              req_valid[i] = 1'b0;
            end else begin
              req_data[i*DW +: DW] = DW'($urandom);
            end
          end else if (!req_valid[i]) begin
            if ($urandom_range(99) < ph_req[p]) begin
              req_valid[i]         = 1'b1;
              req_data[i*DW +: DW] = DW'($urandom);
            end
          end else if (m_owner == i && $urandom_range(49) == 0) begin
            req_valid[i] = 1'b0;
          end
        end

        rst_n = 1'b1;
        if (c < 2 && p == 0) rst_n = 1'b0;
        else if (ph_rst[p] != 0) begin
          if ($urandom_range(299) == 0) rst_n = 1'b0;
          else if (m_owner >= 0 && m_age > 2 && $urandom_range(9) == 0) rst_n = 1'b0;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
